// File: rtl/hack_pkg.sv
// Shared constants and encodings for the Hack datapath blocks.
package hack_pkg;

    // Default Hack machine word width.
    localparam int unsigned HACK_WIDTH = 16;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Operation select encoding.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the bit-serial arithmetic path.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and carry of one bit position.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one shared full adder stepped LSB to MSB,
// with valid/ready handshakes on operands and results.
module serial_adder_ctrl
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = HACK_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    // Holds the low WIDTH-1 sum bits; the MSB sum joins them on the last step.
    logic [WIDTH-2:0]   r_sh_q, r_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;

    logic               fa_sum;
    logic               fa_cout;

    // The only arithmetic cell: fed by the operand LSBs and the carry register.
    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State, datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            r_sh_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            r_sh_q      <= r_sh_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        r_sh_d      = r_sh_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1: invert b and seed the carry.
                    a_sh_d  = a;
                    b_sh_d  = (sub == OP_SUB) ? ~b : b;
                    carry_d = (sub == OP_SUB);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = (r_sh_q >> 1) | ((WIDTH-1)'(fa_sum) << (WIDTH-2));
                carry_d = fa_cout;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    // MSB step: overflow is carry-in XOR carry-out of the sign bit.
                    result_d    = {fa_sum, r_sh_q};
                    carry_out_d = fa_cout;
                    overflow_d  = fa_cout ^ carry_q;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status decode from state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=16) with a result scoreboard.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;
    exp_t sb[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Reference: wide two's-complement arithmetic.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t         m;
        logic [W-1:0] yy;
        logic [W:0]   full;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + (W+1)'(s);
        m.r  = full[W-1:0];
        m.c  = full[W];
        m.v  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return m;
    endfunction

    // Called just after a negedge; returns just after the negedge following the accept edge.
    task automatic start_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic s, input bit push);
        a        = x;
        b        = y;
        sub      = s;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        if (push) sb.push_back(model(x, y, s));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid from the negedge after the accept edge; checks latency and result.
    task automatic wait_done(input string tag);
        int   cnt;
        exp_t e;
        cnt = 0;
        while (!out_valid && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, 64'(cnt), 64'(W));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_result"},    64'(result),    64'(e.r));
            check({tag, "_carry_out"}, 64'(carry_out), 64'(e.c));
            check({tag, "_overflow"},  64'(overflow),  64'(e.v));
        end
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_vld_low"}, 64'(out_valid), 64'(0));
        check({tag, "_rdy_back"}, 64'(in_ready), 64'(1));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s);
        start_op(tag, x, y, s, 1'b1);
        wait_done(tag);
        take_result(tag);
    endtask

    initial begin
        logic [W-1:0] held_r;
        logic         held_c;
        logic         held_v;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_result",    64'(result),    64'(0));
        check("rst_carry",     64'(carry_out), 64'(0));
        check("rst_ovf",       64'(overflow),  64'(0));
        rst = 1'b0;
        @(negedge clk);

        run_op("add_1_1",      16'h0001, 16'h0001, 1'b0);
        check("add_1_1_const_r", 64'(result), 64'h0002);
        run_op("add_ffff_1",   16'hFFFF, 16'h0001, 1'b0);
        check("add_ffff_1_const_c", 64'(carry_out), 64'(1));
        run_op("add_7fff_1",   16'h7FFF, 16'h0001, 1'b0);
        check("add_7fff_1_const_v", 64'(overflow), 64'(1));
        run_op("sub_5_7",      16'h0005, 16'h0007, 1'b1);
        check("sub_5_7_const_r", 64'(result), 64'hFFFE);
        run_op("sub_8000_1",   16'h8000, 16'h0001, 1'b1);
        check("sub_8000_1_const_r", 64'(result), 64'h7FFF);

        // Backpressure: DONE held with a new op waiting on the input.
        start_op("bp", 16'hA5A5, 16'h1111, 1'b0, 1'b1);
        wait_done("bp");
        held_r   = result;
        held_c   = carry_out;
        held_v   = overflow;
        a        = 16'h0100;
        b        = 16'h0300;
        sub      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_in_ready",  64'(in_ready),  64'(0));
            check("bp_result",    64'(result),    64'(held_r));
            check("bp_flags",     64'({carry_out, overflow}), 64'({held_c, held_v}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_hs_vld_low", 64'(out_valid), 64'(0));
        check("bp_hs_in_ready", 64'(in_ready), 64'(1));
        sb.push_back(model(16'h0100, 16'h0300, 1'b1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_pending_busy", 64'(busy), 64'(1));
        wait_done("bp_pending");
        take_result("bp_pending");

        // Reset during RUN, after bit 6 has been processed (counter at 7).
        start_op("rst_run", 16'h1234, 16'h4321, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        check("rst_run_busy_pre", 64'(busy), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rst_run_busy",      64'(busy),      64'(0));
        check("rst_run_in_ready",  64'(in_ready),  64'(1));
        check("rst_run_out_valid", 64'(out_valid), 64'(0));
        check("rst_run_result",    64'(result),    64'(0));
        check("rst_run_flags",     64'({carry_out, overflow}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("after_rst", 16'h1234, 16'h4321, 1'b0);
        check("after_rst_const_r", 64'(result), 64'h5555);

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
